response_queue: RTL and testbench

Parametrised response FIFO between the memory controller's read-data path and the host-side response port. It replaces the fixed 8-deep, 65-bit response buffer. It adds configurable width and depth, and allows a read and a write in the same cycle. It also provides full/almost-full back-pressure, an occupancy count, sticky overflow/underflow flags, and a selectable output mode (registered or first-word-fall-through).

---
 rtl/response_queue_if.sv | 31 +++
 rtl/response_queue.sv | 99 +++++++++
 tb/tb_response_queue.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/response_queue_if.sv
// Handshake bundle between the read-data path (master) and the response queue
// (slave). It carries the write and pop requests, the read data, the status flags and the occupancy count.
interface response_queue_if #(
  parameter int DATA_W = 65,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] in_data;
  logic              wen;
  logic              read;
  logic              clr_err;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              res_ctrl;
  logic              full;
  logic              almost_full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output in_data, wen, read, clr_err,
    input  out_data, out_valid, res_ctrl, full, almost_full, count, overflow, underflow
  );

  modport slave (
    input  in_data, wen, read, clr_err,
    output out_data, out_valid, res_ctrl, full, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/response_queue.sv
// Parametrised response FIFO with same-cycle read/write, sticky error flags
// and a choice of registered or first-word-fall-through output.
module response_queue #(
  parameter int DATA_W   = 65,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int FWFT     = 0
) (
  input  logic               clk,
  input  logic               reset,
  response_queue_if.slave    bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr_write;
  logic [PTR_W-1:0]  ptr_read;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;
  logic              empty;
  logic              is_full;
  logic              rd_acc;
  logic              wr_acc;

  // Status is decoded only from the registered count, so wen/read never
  // reach these flags combinationally.
  assign empty   = (count == '0);
  assign is_full = (count == CNT_W'(DEPTH));

  // A write into a full queue is taken only when a pop frees a slot on the same edge.
  assign rd_acc = bus.read & ~empty;
  assign wr_acc = bus.wen & (~is_full | rd_acc);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_write <= '0;
      ptr_read  <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) ptr_write <= ptr_write + PTR_W'(1);
      if (rd_acc) ptr_read  <= ptr_read + PTR_W'(1);

      if (wr_acc && !rd_acc)      count <= count + CNT_W'(1);
      else if (rd_acc && !wr_acc) count <= count - CNT_W'(1);

      // A new error in the same cycle as clr_err wins.
      if (bus.wen && !wr_acc) overflow <= 1'b1;
      else if (bus.clr_err)   overflow <= 1'b0;

      if (bus.read && empty)  underflow <= 1'b1;
      else if (bus.clr_err)   underflow <= 1'b0;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers and count define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[ptr_write] <= bus.in_data;
  end

  generate
    if (FWFT == 0) begin : g_registered
      logic [DATA_W-1:0] out_data;
      logic              out_valid;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          out_data  <= '0;
          out_valid <= 1'b0;
        end else begin
          out_valid <= rd_acc;
          if (rd_acc) out_data <= mem[ptr_read];
        end
      end

      assign bus.out_data  = out_data;
      assign bus.out_valid = out_valid;
    end else begin : g_fwft
      // Head entry is presented directly; read acknowledges it.
      assign bus.out_data  = mem[ptr_read];
      assign bus.out_valid = ~empty;
    end
  endgenerate

  assign bus.res_ctrl    = ~empty;
  assign bus.full        = is_full;
  assign bus.almost_full = (count >= CNT_W'(AF_LEVEL));
  assign bus.count       = count;
  assign bus.overflow    = overflow;
  assign bus.underflow   = underflow;

endmodule

// File: tb/tb_response_queue.sv
// Scoreboard bench for response_queue: a registered 8-deep instance and a
// 4-deep first-word-fall-through instance share one clock and reset.
module tb_response_queue;

  localparam int DW = 65;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  response_queue_if #(.DATA_W(DW), .DEPTH(8)) b0 ();
  response_queue_if #(.DATA_W(DW), .DEPTH(4)) b1 ();

  response_queue #(.DATA_W(DW), .DEPTH(8), .AF_LEVEL(6), .FWFT(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  response_queue #(.DATA_W(DW), .DEPTH(4), .AF_LEVEL(3), .FWFT(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  int vectors = 0;
  int errors  = 0;
  int n0      = 0;
  int n1      = 0;
  int max_cnt = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock of the registered instance, with model update before the edge
  // and checks 1 ns after it.
  task automatic cyc0(input logic w, input logic r, input logic [DW-1:0] d, input logic ce);
    logic          rd;
    logic          wa;
    logic [DW-1:0] exp_d;
    exp_d      = '0;
    b1.wen     = 1'b0;
    b1.read    = 1'b0;
    b1.clr_err = 1'b0;
    b0.wen     = w;
    b0.read    = r;
    b0.in_data = d;
    b0.clr_err = ce;
    rd = r && (q0.size() != 0);
    wa = w && ((q0.size() != 8) || rd);
    if (rd) exp_d = q0.pop_front();
    if (wa) q0.push_back(d);
    if (w && !wa)    m_ovf = 1'b1;
    else if (ce)     m_ovf = 1'b0;
    if (r && !rd)    m_udf = 1'b1;
    else if (ce)     m_udf = 1'b0;
    @(posedge clk);
    #1;
    n0++;
    check($sformatf("c%0d.count", n0),     DW'(b0.count),       DW'(q0.size()));
    check($sformatf("c%0d.res_ctrl", n0),  DW'(b0.res_ctrl),    DW'(q0.size() != 0));
    check($sformatf("c%0d.full", n0),      DW'(b0.full),        DW'(q0.size() == 8));
    check($sformatf("c%0d.af", n0),        DW'(b0.almost_full), DW'(q0.size() >= 6));
    check($sformatf("c%0d.out_valid", n0), DW'(b0.out_valid),   DW'(rd));
    check($sformatf("c%0d.overflow", n0),  DW'(b0.overflow),    DW'(m_ovf));
    check($sformatf("c%0d.underflow", n0), DW'(b0.underflow),   DW'(m_udf));
    if (rd) check($sformatf("c%0d.out_data", n0), b0.out_data, exp_d);
    if (int'(b0.count) > max_cnt) max_cnt = int'(b0.count);
  endtask

  // One clock of the fall-through instance; the head must be visible without a read.
  task automatic cyc1(input logic w, input logic r, input logic [DW-1:0] d);
    logic rd;
    logic wa;
    b0.wen     = 1'b0;
    b0.read    = 1'b0;
    b0.clr_err = 1'b0;
    b1.wen     = w;
    b1.read    = r;
    b1.in_data = d;
    b1.clr_err = 1'b0;
    rd = r && (q1.size() != 0);
    wa = w && ((q1.size() != 4) || rd);
    if (rd) void'(q1.pop_front());
    if (wa) q1.push_back(d);
    @(posedge clk);
    #1;
    n1++;
    check($sformatf("f%0d.count", n1),     DW'(b1.count),       DW'(q1.size()));
    check($sformatf("f%0d.out_valid", n1), DW'(b1.out_valid),   DW'(q1.size() != 0));
    check($sformatf("f%0d.af", n1),        DW'(b1.almost_full), DW'(q1.size() >= 3));
    if (q1.size() != 0) check($sformatf("f%0d.out_data", n1), b1.out_data, q1[0]);
  endtask

  initial begin
    b0.wen = 1'b0; b0.read = 1'b0; b0.clr_err = 1'b0; b0.in_data = '0;
    b1.wen = 1'b0; b1.read = 1'b0; b1.clr_err = 1'b0; b1.in_data = '0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst.count",     DW'(b0.count),       '0);
    check("rst.out_valid", DW'(b0.out_valid),   '0);
    check("rst.out_data",  b0.out_data,         '0);
    check("rst.res_ctrl",  DW'(b0.res_ctrl),    '0);
    check("rst.full",      DW'(b0.full),        '0);
    check("rst.af",        DW'(b0.almost_full), '0);
    check("rst.ovf",       DW'(b0.overflow),    '0);
    check("rst.udf",       DW'(b0.underflow),   '0);
    check("rst.fwft_vld",  DW'(b1.out_valid),   '0);
    reset = 1'b1;

    // Fill 1..8, then a rejected 9th write
    for (int i = 1; i <= 8; i++) cyc0(1'b1, 1'b0, DW'(i), 1'b0);
    cyc0(1'b1, 1'b0, DW'(9), 1'b0);
    // Simultaneous push/pop at full: count stays 8, no new overflow cause
    cyc0(1'b1, 1'b1, DW'('hA), 1'b0);
    // Drain: 2..8 then 0xA, proving the rejected 9 was never stored
    for (int i = 0; i < 8; i++) cyc0(1'b0, 1'b1, '0, 1'b0);
    // Underflow on empty read, then clear both flags
    cyc0(1'b0, 1'b1, '0, 1'b0);
    cyc0(1'b0, 1'b0, '0, 1'b1);

    // clr_err coinciding with a rejected write keeps overflow set
    for (int i = 0; i < 8; i++) cyc0(1'b1, 1'b0, DW'('h20 + i), 1'b0);
    cyc0(1'b1, 1'b0, DW'('h2F), 1'b1);
    for (int i = 0; i < 8; i++) cyc0(1'b0, 1'b1, '0, 1'b0);
    cyc0(1'b0, 1'b0, '0, 1'b1);

    // Empty with wen and read together: write taken, read rejected
    cyc0(1'b1, 1'b1, DW'('h33), 1'b0);
    cyc0(1'b0, 1'b0, '0, 1'b1);

    // Wrap-around around occupancy 3
    cyc0(1'b1, 1'b0, DW'('h34), 1'b0);
    cyc0(1'b1, 1'b0, DW'('h35), 1'b0);
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc0(1'b1, 1'b0, DW'('h100 + i), 1'b0);
      cyc0(1'b0, 1'b1, '0, 1'b0);
    end
    check("wrap.max_le4", DW'(max_cnt <= 4), DW'(1));

    // Reach count 5 with the last cycle also popping, so out_valid is high
    cyc0(1'b1, 1'b0, DW'('h200), 1'b0);
    cyc0(1'b1, 1'b0, DW'('h201), 1'b0);
    cyc0(1'b1, 1'b1, DW'('h202), 1'b0);

    // Asynchronous reset in the middle of a cycle
    #3;
    reset = 1'b0;
    #1;
    check("arst.count",     DW'(b0.count),     '0);
    check("arst.res_ctrl",  DW'(b0.res_ctrl),  '0);
    check("arst.full",      DW'(b0.full),      '0);
    check("arst.out_valid", DW'(b0.out_valid), '0);
    check("arst.out_data",  b0.out_data,       '0);
    q0.delete();
    q1.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(posedge clk);
    #1;
    check("arst.hold_count", DW'(b0.count), '0);
    @(negedge clk);
    reset = 1'b1;
    cyc0(1'b1, 1'b0, DW'(7), 1'b0);
    cyc0(1'b0, 1'b1, '0, 1'b0);

    // Fall-through instance
    cyc1(1'b1, 1'b0, DW'('h55));
    cyc1(1'b0, 1'b0, '0);
    cyc1(1'b0, 1'b1, '0);
    cyc1(1'b1, 1'b0, DW'('h11));
    cyc1(1'b1, 1'b0, DW'('h22));
    cyc1(1'b0, 1'b1, '0);
    cyc1(1'b1, 1'b0, DW'('h33));
    cyc1(1'b1, 1'b0, DW'('h44));
    cyc1(1'b1, 1'b0, DW'('h66));
    cyc1(1'b1, 1'b1, DW'('h77));
    for (int i = 0; i < 5; i++) cyc1(1'b0, 1'b1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
